// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        id_memwrite_i,
  input  logic        id_memtoreg_i,
  input  logic        id_alusrc_i,
  input  logic [3:0]  id_aluop_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rdata1_i,
  input  logic [31:0] id_rdata2_i,
  input  logic [31:0] id_imm_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        ex_valid_o,
  output logic        ex_regwrite_o,
  output logic        ex_memread_o,
  output logic        ex_memwrite_o,
  output logic        ex_memtoreg_o,
  output logic        ex_alusrc_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [3:0]  ex_aluop_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rdata1_o,
  output logic [31:0] ex_rdata2_o,
  output logic [31:0] ex_imm_o,
  output logic        hazard_stall_o,
  output logic [15:0] bubble_cnt_o
);

  logic [15:0] bubble_cnt_q;
  logic        rs1_dep;
  logic        rs2_dep;

  // A load in EX whose destination an ID operand actually reads; x0 never creates a dependency.
  assign rs1_dep = id_use_rs1_i && (id_rs1_i == ex_rd_o);
  assign rs2_dep = id_use_rs2_i && (id_rs2_i == ex_rd_o);
  assign hazard_stall_o = !flush_i && id_valid_i && ex_valid_o && ex_memread_o &&
                          (ex_rd_o != 5'd0) && (rs1_dep || rs2_dep);
  assign bubble_cnt_o = bubble_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!hold_i && hazard_stall_o)) begin
      ex_valid_o    <= 1'b0;
      ex_regwrite_o <= 1'b0;
      ex_memread_o  <= 1'b0;
      ex_memwrite_o <= 1'b0;
      ex_memtoreg_o <= 1'b0;
      ex_alusrc_o   <= 1'b0;
      ex_rs1_o      <= 5'd0;
      ex_rs2_o      <= 5'd0;
      ex_rd_o       <= 5'd0;
      ex_aluop_o    <= 4'd0;
      ex_pc_o       <= 32'd0;
      ex_rdata1_o   <= 32'd0;
      ex_rdata2_o   <= 32'd0;
      ex_imm_o      <= 32'd0;
    end else if (!hold_i) begin
      // Invalid slots must never write state, so side-effecting controls are gated here.
      ex_valid_o    <= id_valid_i;
      ex_regwrite_o <= id_valid_i && id_regwrite_i;
      ex_memread_o  <= id_valid_i && id_memread_i;
      ex_memwrite_o <= id_valid_i && id_memwrite_i;
      ex_memtoreg_o <= id_memtoreg_i;
      ex_alusrc_o   <= id_alusrc_i;
      ex_rs1_o      <= id_rs1_i;
      ex_rs2_o      <= id_rs2_i;
      ex_rd_o       <= id_valid_i ? id_rd_i : 5'd0;
      ex_aluop_o    <= id_aluop_i;
      ex_pc_o       <= id_pc_i;
      ex_rdata1_o   <= id_rdata1_i;
      ex_rdata2_o   <= id_rdata2_i;
      ex_imm_o      <= id_imm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= 16'd0;
    end else if (!flush_i && !hold_i && hazard_stall_o && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - randomized self-checking bench for id_ex_reg against a behavioural model
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, id_valid, use1, use2, id_rw, id_mr, id_mw, id_mtr, id_as, flush, hold;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_aluop;
  logic [31:0] id_pc, id_d1, id_d2, id_imm;

  logic        ex_valid, ex_rw, ex_mr, ex_mw, ex_mtr, ex_as, hz;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_pc, ex_d1, ex_d2, ex_imm;
  logic [15:0] bcnt;

  // Expected EX contents, kept as plain variables updated from the priority rules.
  logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_as;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_aluop;
  logic [31:0] m_pc, m_d1, m_d2, m_imm;
  int          m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr), .id_memwrite_i(id_mw),
    .id_memtoreg_i(id_mtr), .id_alusrc_i(id_as), .id_aluop_i(id_aluop),
    .id_pc_i(id_pc), .id_rdata1_i(id_d1), .id_rdata2_i(id_d2), .id_imm_i(id_imm),
    .flush_i(flush), .hold_i(hold),
    .ex_valid_o(ex_valid), .ex_regwrite_o(ex_rw), .ex_memread_o(ex_mr),
    .ex_memwrite_o(ex_mw), .ex_memtoreg_o(ex_mtr), .ex_alusrc_o(ex_as),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_aluop_o(ex_aluop),
    .ex_pc_o(ex_pc), .ex_rdata1_o(ex_d1), .ex_rdata2_o(ex_d2), .ex_imm_o(ex_imm),
    .hazard_stall_o(hz), .bubble_cnt_o(bcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    {m_valid, m_rw, m_mr, m_mw, m_mtr, m_as} = '0;
    {m_rs1, m_rs2, m_rd, m_aluop} = '0;
    {m_pc, m_d1, m_d2, m_imm} = '0;
  endtask

  function automatic logic exp_hazard();
    logic dep;
    dep = (use1 && id_rs1 == m_rd) || (use2 && id_rs2 == m_rd);
    return !flush && id_valid && m_valid && m_mr && (m_rd != 0) && dep;
  endfunction

  task automatic rand_id();
    id_valid = ($urandom_range(0, 4) != 0);
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    use1 = 1'($urandom); use2 = 1'($urandom);
    id_rw = 1'($urandom); id_mr = 1'($urandom); id_mw = 1'($urandom);
    id_mtr = 1'($urandom); id_as = 1'($urandom); id_aluop = 4'($urandom);
    id_pc = $urandom; id_d1 = $urandom; id_d2 = $urandom; id_imm = $urandom;
  endtask

  task automatic clear_ctl();
    rst = 0; flush = 0; hold = 0;
  endtask

  // One clock: check the combinational stall, advance the model, then check every registered output.
  task automatic cycle();
    logic h;
    #1;
    h = exp_hazard();
    check("hazard", hz, h);
    if (rst) begin
      m_clear(); m_cnt = 0;
    end else if (flush) begin
      m_clear();
    end else if (hold) begin
    end else if (h) begin
      m_clear(); m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      m_valid = id_valid;
      m_rw = id_valid & id_rw; m_mr = id_valid & id_mr; m_mw = id_valid & id_mw;
      m_mtr = id_mtr; m_as = id_as; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_rd = id_valid ? id_rd : 5'd0; m_aluop = id_aluop;
      m_pc = id_pc; m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm;
    end
    @(posedge clk);
    #1;
    check("ctrl", {ex_valid, ex_rw, ex_mr, ex_mw, ex_mtr, ex_as}, {m_valid, m_rw, m_mr, m_mw, m_mtr, m_as});
    check("idx", {ex_rs1, ex_rs2, ex_rd}, {m_rs1, m_rs2, m_rd});
    check("aluop", ex_aluop, m_aluop);
    check("pc", ex_pc, m_pc);
    check("rdata", {ex_d1, ex_d2}, {m_d1, m_d2});
    check("imm", ex_imm, m_imm);
    check("bubble_cnt", bcnt, 64'(m_cnt));
    check("rw_without_valid", ex_rw & ~ex_valid, 0);
  endtask

  task automatic set_load(input logic [4:0] rd);
    rand_id();
    id_valid = 1; id_mr = 1; id_rw = 1; id_rd = rd; use1 = 0; use2 = 0;
  endtask

  task automatic set_user(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    rand_id();
    id_valid = 1; id_mr = 0; id_rd = 5'd9;
    id_rs1 = rs1; use1 = u1; id_rs2 = rs2; use2 = u2;
  endtask

  initial begin
    m_clear(); m_cnt = 0;
    rand_id(); clear_ctl();
    @(posedge clk); #1;
    rst = 1; flush = 1; hold = 1;
    cycle();
    check("reset_cnt", bcnt, 0);
    clear_ctl();

    // Plain load
    rand_id(); id_valid = 1; id_rd = 5'd5; id_rw = 1; id_d1 = 32'h1234;
    cycle();
    check("plain_valid", ex_valid, 1);
    check("plain_rd", ex_rd, 5);
    check("plain_rdata1", ex_d1, 32'h1234);

    // Load-use on rs2, then the stalled add proceeds
    set_load(5'd7); cycle();
    set_user(5'd1, 1, 5'd7, 1);
    #1 check("lu_stall", hz, 1);
    cycle();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_mr", ex_mr, 0);
    check("lu_cnt", bcnt, 1);
    cycle();
    check("lu_add_loaded", ex_rd, 9);

    // x0 destination and unused operand
    set_load(5'd0); cycle();
    set_user(5'd0, 1, 5'd0, 1);
    #1 check("x0_no_stall", hz, 0);
    cycle();
    set_load(5'd3); cycle();
    set_user(5'd3, 0, 5'd2, 1);
    #1 check("unused_no_stall", hz, 0);
    cycle();

    // Flush overrides hazard; count unchanged
    set_load(5'd7); cycle();
    set_user(5'd7, 1, 5'd0, 0); flush = 1;
    #1 check("flush_no_stall", hz, 0);
    cycle();
    check("flush_cnt", bcnt, 1);
    check("flush_valid", ex_valid, 0);
    flush = 0;

    // Hold for three cycles with changing inputs, then flush during hold
    set_load(5'd4); cycle();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id(); cycle();
    end
    check("hold_rd", ex_rd, 4);
    flush = 1; cycle();
    check("hold_flush_valid", ex_valid, 0);
    clear_ctl();

    // Saturation: preload counter near the top, then two hazards
    force dut.bubble_cnt_q = 16'hFFFE;
    #1 release dut.bubble_cnt_q;
    m_cnt = 65534;
    for (int i = 0; i < 2; i++) begin
      set_load(5'd6); cycle();
      set_user(5'd6, 1, 5'd0, 0); cycle();
    end
    check("sat_cnt", bcnt, 16'hFFFF);
    set_load(5'd6); cycle();
    set_user(5'd6, 1, 5'd0, 0); cycle();
    check("sat_hold", bcnt, 16'hFFFF);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_id();
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Final reset with a pending hazard
    clear_ctl();
    set_load(5'd2); cycle();
    set_user(5'd2, 1, 5'd0, 0); rst = 1;
    cycle();
    check("final_rst_cnt", bcnt, 0);
    check("final_rst_valid", ex_valid, 0);
    clear_ctl();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
